// File: rtl/endpoint_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC endpoint injection port
// among NREQ requesters, with downstream credit tracking and a registered output.
module endpoint_inject_arbiter #(
    parameter int NREQ   = 4,
    parameter int FLIT_W = 32,
    parameter int CREDIT = 4,
    parameter int CW     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ-1:0]           req_hdr,
    input  logic [NREQ-1:0]           req_tail,
    input  logic [NREQ*FLIT_W-1:0]    req_flit,
    output logic [NREQ-1:0]           req_ready,
    output logic [FLIT_W-1:0]         flit_out,
    output logic                      flit_out_hdr,
    output logic                      flit_out_tail,
    output logic                      flit_out_wr,
    input  logic                      credit_in,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic [15:0]               pkt_sent,
    output logic                      err
);

    localparam int OW = $clog2(NREQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q;
    logic [OW-1:0]       rr_ptr_q;
    logic [OW-1:0]       owner_q;
    logic [CW-1:0]       credit_q;
    logic [CW-1:0]       credit_d;
    logic [FLIT_W-1:0]   flit_q;
    logic                hdr_q;
    logic                tail_q;
    logic                wr_q;
    logic [15:0]         pkt_sent_q;
    logic                err_q;

    logic                found;
    logic [OW-1:0]       winner;
    logic [OW-1:0]       sel;
    logic [NREQ-1:0]     grant;
    logic                can_send;
    logic                xfer;
    logic [FLIT_W-1:0]   sel_flit;
    logic                sel_hdr;
    logic                sel_tail;
    int                  scan_idx;

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] p);
        return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
    endfunction

    // Round-robin head search from rr_ptr; only head flits compete while idle.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (!found && req_valid[scan_idx] && req_hdr[scan_idx]) begin
                found  = 1'b1;
                winner = OW'(scan_idx);
            end
        end
    end

    assign can_send = (credit_q != '0);
    assign sel      = (state_q == IDLE) ? winner : owner_q;

    always_comb begin
        grant = '0;
        if (state_q == IDLE) begin
            if (found && can_send) grant[winner] = 1'b1;
        end else begin
            grant[owner_q] = can_send;
        end
    end

    // Ready is forced low for the whole time reset is held.
    assign req_ready = reset ? grant : '0;
    assign xfer      = |(req_ready & req_valid);

    always_comb begin
        sel_flit = '0;
        sel_hdr  = 1'b0;
        sel_tail = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (OW'(i) == sel) begin
                sel_flit = req_flit[i*FLIT_W +: FLIT_W];
                sel_hdr  = req_hdr[i];
                sel_tail = req_tail[i];
            end
        end
    end

    always_comb begin
        credit_d = credit_q;
        if (xfer && !credit_in)
            credit_d = credit_q - 1'b1;
        else if (!xfer && credit_in && credit_q != CW'(CREDIT))
            credit_d = credit_q + 1'b1;
    end

    // Mid-packet reset abandons the packet and restores full credit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            credit_q   <= CW'(CREDIT);
            flit_q     <= '0;
            hdr_q      <= 1'b0;
            tail_q     <= 1'b0;
            wr_q       <= 1'b0;
            pkt_sent_q <= '0;
            err_q      <= 1'b0;
        end else begin
            credit_q <= credit_d;
            wr_q     <= xfer;
            if (xfer) begin
                flit_q <= sel_flit;
                hdr_q  <= sel_hdr;
                tail_q <= sel_tail;
            end
            if (xfer && sel_tail) pkt_sent_q <= pkt_sent_q + 1'b1;
            if (!xfer && credit_in && credit_q == CW'(CREDIT)) err_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        owner_q <= winner;
                        if (sel_tail) rr_ptr_q <= next_idx(winner);
                        else          state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        if (sel_hdr) err_q <= 1'b1;
                        if (sel_tail) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_idx(owner_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flit_out      = flit_q;
    assign flit_out_hdr  = hdr_q;
    assign flit_out_tail = tail_q;
    assign flit_out_wr   = wr_q;
    assign owner         = owner_q;
    assign busy          = (state_q == BUSY);
    assign pkt_sent      = pkt_sent_q;
    assign err           = err_q;

endmodule
